adder_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit adder (sum + carry-out) between N_REQ requesters using round-robin arbitration.

---
 rtl/adder_share_arbiter.sv | 114 +++++++++++
 tb/tb_adder_share_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | adder_share_arbiter: one WIDTH-bit adder shared round-robin by N_REQ requesters,  |
// | result held in a one-entry slot. Option macro ADDER_SHARE_SAT_EN = saturating add.|
// | Revision: 1.0                                                                      |
// +-----------------------------------------------------------------------------------+
module adder_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_co
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_co_q;

  logic             grant_ok_w;
  logic             grant_found_w;
  logic             grant_w;
  logic [IDW-1:0]   grant_id_w;
  logic [WIDTH-1:0] op_a_w, op_b_w;
  logic [WIDTH:0]   raw_sum_w;
  logic [WIDTH-1:0] sum_d;
  logic             co_d;

  // Walk offsets from highest to lowest so the requester nearest rr_ptr is the last to overwrite.
  always_comb begin
    int idx;
    idx           = 0;
    grant_found_w = 1'b0;
    grant_id_w    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        grant_found_w = 1'b1;
        grant_id_w    = IDW'(idx);
      end
    end
  end

  assign grant_ok_w = rstN && ((state_q == EMPTY) || rsp_ready);
  assign grant_w    = grant_ok_w && grant_found_w;

  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_w] = grant_w;
  end

  assign op_a_w    = req_a[grant_id_w*WIDTH +: WIDTH];
  assign op_b_w    = req_b[grant_id_w*WIDTH +: WIDTH];
  assign raw_sum_w = {1'b0, op_a_w} + {1'b0, op_b_w};

`ifdef ADDER_SHARE_SAT_EN
  assign sum_d = raw_sum_w[WIDTH] ? {WIDTH{1'b1}} : raw_sum_w[WIDTH-1:0];
  assign co_d  = raw_sum_w[WIDTH];
`else
  assign sum_d = raw_sum_w[WIDTH-1:0];
  assign co_d  = raw_sum_w[WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant_w) state_d = FULL;
      FULL:    if (rsp_ready && !grant_w) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_w) begin
        rsp_sum_q <= sum_d;
        rsp_co_q  <= co_d;
        rsp_id_q  <= grant_id_w;
        rr_ptr_q  <= (grant_id_w == IDW'(N_REQ - 1)) ? '0 : grant_id_w + 1'b1;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// Directed self-checking bench for adder_share_arbiter (N_REQ=4, WIDTH=32).
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rstN;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_co;

  int n_checks = 0;
  int n_pass   = 0;

  adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) u_dut (
    .clk       (clk),
    .rstN      (rstN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Per-requester sums for the rotation phase: a_i = 0x1000_0000*i + i, b_i = 0x10 + i.
  logic [W-1:0] rot_sum [N];
  logic [1:0]   exp_g   [6];
  logic [W-1:0] held_sum;
  logic [1:0]   held_id;

  initial begin
    rot_sum[0] = 32'h0000_0010;
    rot_sum[1] = 32'h1000_0012;
    rot_sum[2] = 32'h2000_0014;
    rot_sum[3] = 32'h3000_0016;
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2;
    exp_g[3] = 2'd3; exp_g[4] = 2'd0; exp_g[5] = 2'd1;

    // Reset with everyone requesting
    rstN = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    #3;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_valid", 64'(rsp_valid), 64'h0);
    @(negedge clk); @(negedge clk);
    check("rst_sum", 64'(rsp_sum), 64'h0);
    check("rst_co", 64'(rsp_co), 64'h0);
    check("rst_id", 64'(rsp_id), 64'h0);
    check("rst_ready2", 64'(req_ready), 64'h0);

    // Single request from ID 2
    rstN = 1'b1; req_valid = 4'b0100; set_op(2, 32'h5, 32'h7);
    #4;
    check("single_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_id", 64'(rsp_id), 64'h2);
    check("single_sum", 64'(rsp_sum), 64'hC);
    check("single_co", 64'(rsp_co), 64'h0);
    req_valid = 4'b0000; rsp_ready = 1'b1;
    #4;
    check("single_noready", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("drain_valid", 64'(rsp_valid), 64'h0);
    check("drain_sum_kept", 64'(rsp_sum), 64'hC);

    // Overflow from ID 0 (rr_ptr=3, search 3 -> 0)
    req_valid = 4'b0001; set_op(0, 32'hFFFF_FFFF, 32'h2);
    #4;
    check("ovf_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    check("ovf_id", 64'(rsp_id), 64'h0);
`ifdef ADDER_SHARE_SAT_EN
    check("ovf_sum", 64'(rsp_sum), 64'hFFFF_FFFF);
`else
    check("ovf_sum", 64'(rsp_sum), 64'h1);
`endif
    check("ovf_co", 64'(rsp_co), 64'h1);
    req_valid = 4'b0000;
    @(negedge clk);
    check("ovf_drain", 64'(rsp_valid), 64'h0);

    // Reset pulse so the rotation starts from ID 0
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'h1000_0000 * i + i, 32'h10 + i);
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check("rot_valid", 64'(rsp_valid), 64'h1);
        check("rot_id", 64'(rsp_id), 64'(exp_g[k-1]));
        check("rot_sum", 64'(rsp_sum), 64'(rot_sum[exp_g[k-1]]));
      end
      #4;
      check("rot_ready", 64'(req_ready), 64'(4'b0001 << exp_g[k]));
    end
    @(negedge clk);
    check("rot_last_id", 64'(rsp_id), 64'h1);
    check("rot_last_sum", 64'(rsp_sum), 64'(rot_sum[1]));

    // Backpressure: slot holds ID 1, rr_ptr=2
    held_sum = rsp_sum; held_id = rsp_id;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #4;
      check("bp_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'h1);
      check("bp_id", 64'(rsp_id), 64'h1);
      check("bp_sum", 64'(rsp_sum), 64'(rot_sum[1]));
    end
    rsp_ready = 1'b1;
    #4;
    check("bp_release_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    check("bp_release_valid", 64'(rsp_valid), 64'h1);
    check("bp_release_id", 64'(rsp_id), 64'h2);
    check("bp_release_sum", 64'(rsp_sum), 64'(rot_sum[2]));

    // Mid-operation reset while FULL
    rsp_ready = 1'b0; req_valid = 4'b1000;
    #4;
    check("mid_full_ready", 64'(req_ready), 64'h0);
    #2;
    rstN = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'h0);
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rstN = 1'b1; req_valid = 4'b1010;
    #4;
    check("after_rst_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    check("after_rst_valid", 64'(rsp_valid), 64'h1);
    check("after_rst_id", 64'(rsp_id), 64'h1);
    check("after_rst_sum", 64'(rsp_sum), 64'(rot_sum[1]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
